// File: rtl/uart_rx_monitor.sv
// Purpose: recover 8N1 (8E1 with UART_MON_PARITY_EN) bytes from a UART line into a byte FIFO with flags.
// Latency: 2-cycle sync + mid-bit sampling; byte visible on m_valid one cycle after the stop-bit sample.
// Backpressure: m_valid/m_ready drains the FIFO; when full a received byte is dropped and overflow is set.

// Byte FIFO with a registered head: m_data holds the last byte when empty, pointers carry an extra MSB.
module uart_rx_mon_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [7:0]               push_dat,
  output logic                     push_acc,
  output logic                     push_drop,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [7:0]               head_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d, lvl_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  head_q, head_d;
  logic        pop;
  logic        full;

  assign level    = wr_q - rd_q;
  assign full     = (level == FULL_LVL);
  assign head_vld = (level != '0);
  assign head_dat = head_q;
  assign pop      = head_vld & pop_rdy;
  // A full FIFO still takes a byte if the head leaves in the same cycle.
  assign push_acc  = push_vld & (~full | pop);
  assign push_drop = push_vld & full & ~pop;

  // Next pointers and next head byte; bypass the pushed byte when it becomes the new head.
  always_comb begin
    wr_d   = wr_q + {{AW{1'b0}}, push_acc};
    rd_d   = rd_q + {{AW{1'b0}}, pop};
    lvl_d  = wr_d - rd_d;
    head_d = head_q;
    if (lvl_d != '0) begin
      if (push_acc && (rd_d == wr_q)) begin
        head_d = push_dat;
      end else begin
        head_d = mem_q[rd_d[AW-1:0]];
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_q[AW-1:0]] <= push_dat;
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= 8'h00;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end
endmodule

// Top: synchroniser, bit-recovery FSM, FIFO, counters and flags.
module uart_rx_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              baud_div,
  input  logic                     rx,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               m_data,
  output logic                     line_done,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         byte_cnt
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_MON_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  logic             rx_meta_q, rx_sync_q;
  logic [2:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             fire;
  logic             push_vld;
  logic             push_acc;
  logic             push_drop;
  logic             frame_err_c;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] byte_cnt_q;
`ifdef UART_MON_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             par_err_c;
`endif

  // Two-flop synchroniser, preset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // The sample point is reached when the down-counter sits at 1: a load of N samples N cycles later.
  assign fire = (cnt_q == 16'd1);

  // Bit-recovery FSM next state; the divisor is latched at the start bit so later changes wait a frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    push_vld    = 1'b0;
    frame_err_c = 1'b0;
`ifdef UART_MON_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_c   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          div_d   = baud_div;
          cnt_d   = baud_div >> 1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (fire) begin
          if (!rx_sync_q) begin
            cnt_d   = div_q;
            idx_d   = 3'd0;
            state_d = ST_DATA;
`ifdef UART_MON_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (fire) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = div_q;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_MON_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_MON_PARITY_EN
      ST_PARITY: begin
        if (fire) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          par_bad_d = rx_sync_q ^ (^shift_q);
          par_err_c = rx_sync_q ^ (^shift_q);
          cnt_d     = div_q;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (fire) begin
          if (rx_sync_q) begin
`ifdef UART_MON_PARITY_EN
            push_vld = ~par_bad_q;
`else
            push_vld = 1'b1;
`endif
            state_d  = ST_IDLE;
          end else begin
            frame_err_c = 1'b1;
            // All-zero data plus a low stop bit means the line is held low (break).
            state_d     = (shift_q == 8'h00) ? ST_BREAK : ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 16'd0;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
`ifdef UART_MON_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
`ifdef UART_MON_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  uart_rx_mon_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_dat  (shift_q),
    .push_acc  (push_acc),
    .push_drop (push_drop),
    .pop_rdy   (m_ready),
    .head_vld  (m_valid),
    .head_dat  (m_data),
    .level     (level)
  );

  // A fresh drop wins over a simultaneous clear so no overflow event is lost.
  assign overflow_d = (overflow_q & ~clr_overflow) | push_drop;

  // Sticky overflow flag and accepted-byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      if (push_acc) begin
        byte_cnt_q <= byte_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign overflow  = overflow_q;
  assign byte_cnt  = byte_cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_c;
  assign line_done = push_acc & (shift_q == 8'h0A);
`ifdef UART_MON_PARITY_EN
  assign parity_err = par_err_c;
`else
  assign parity_err = 1'b0;
`endif
endmodule
